// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction-memory loader.
//
// Accepts a byte stream (valid/ready handshake) that carries a word count N
// followed by N 32-bit instruction words sent MSB first. Each word is written to
// instruction memory at consecutive addresses starting from BASE_ADDR. The CPU
// is held (cpu_hold=1) from reset or start until the load completes.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to make the stream carry one
// trailing byte. That byte must equal the XOR of the N byte and all data bytes.
// A mismatch sets the sticky err flag and leaves the CPU held.
//
// Parameters
//   ADDR_W     instruction-memory address width (default 8)
//   BASE_ADDR  address of the first loaded word (default 0)
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle load request (honoured only when idle)
//   in_valid   byte-stream valid
//   in_data    byte-stream data
//   in_ready   loader accepts a byte this cycle
//   wr_en      instruction-memory write strobe (one cycle per word)
//   wr_addr    instruction-memory write address
//   wr_data    instruction word to write
//   cpu_hold   holds CPU pc and register writes while high
//   done       one-cycle pulse on successful completion
//   err        sticky checksum-error flag (constant 0 without the checksum)
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   // The word counter must hold both an 8-bit N and the 2**ADDR_W value
   // that N=0 stands for.
   localparam int                CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(1) << ADDR_W;
   localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      FIN
   } state_t;

   state_t           state;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] words_left;
   logic             accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`else
   assign err = 1'b0;
`endif

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= BASE;
         wr_data    <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         byte_cnt   <= '0;
         words_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
         err        <= 1'b0;
`endif
      end else begin
         // The write strobe lasts exactly one cycle; the address advances
         // once that write has been presented.
         wr_en <= 1'b0;
         if (wr_en) begin
            wr_addr <= wr_addr + ADDR_W'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LEN;
                  in_ready   <= 1'b1;
                  cpu_hold   <= 1'b1;
                  wr_addr    <= BASE;
                  byte_cnt   <= '0;
                  words_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= '0;
                  err        <= 1'b0;
`endif
               end
            end

            LEN: begin
               if (accept) begin
                  state      <= DATA;
                  words_left <= (in_data == 8'd0) ? FULL : CNT_W'(in_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= csum ^ in_data;
`endif
               end
            end

            DATA: begin
               if (accept) begin
                  // Shifting in MSB first leaves the 1st byte in [31:24]
                  // after four accepts; older bytes fall off the top.
                  wr_data  <= {wr_data[23:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum ^ in_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     wr_en      <= 1'b1;
                     words_left <= words_left - ONE;
                     if (words_left == ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CSUM;
`else
                        state    <= FIN;
                        in_ready <= 1'b0;
`endif
                     end
                  end
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state <= FIN;
                  end else begin
                     // Bad image: stay held, no done, flag sticks until next start.
                     err   <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
`endif

            FIN: begin
               // First FIN cycle may still carry the last write; done follows
               // in the second cycle, then back to IDLE.
               if (!done) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int ADDR_W = 8;
   localparam int BASE   = 0;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk      = 1'b0;
   logic              rst      = 1'b0;
   logic              start    = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data  = 8'd0;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              err;

   int n_assert = 0;
   int n_fail   = 0;

   // Observed memory writes and done pulses, appended by the monitor.
   logic [ADDR_W-1:0] wa_q[$];
   logic [31:0]       wd_q[$];
   int                done_cnt     = 0;
   logic              hold_at_done = 1'b1;

   imem_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (done === 1'b1) begin
         done_cnt     = done_cnt + 1;
         hold_at_done = cpu_hold;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_wr_en"},    64'(wr_en),    64'd0);
      check({tag, "_wr_addr"},  64'(wr_addr),  64'(BASE));
      check({tag, "_wr_data"},  64'(wr_data),  64'd0);
      check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
      check({tag, "_done"},     64'(done),     64'd0);
      check({tag, "_err"},      64'(err),      64'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // One complete load checked against a model of the stream format.
   // n: count byte (0 means DEPTH words); gap_kind 0=back-to-back, 1=toggle,
   // 2=random stalls; start_at: byte index before which a stray start is
   // pulsed (-1 for none); bad: corrupt the trailing checksum byte.
   task automatic run_load(input string tag, input int n, input int gap_kind,
                           input int start_at, input bit use_first,
                           input logic [31:0] first_w, input bit bad);
      logic [7:0]  stream[$];
      logic [31:0] words[$];
      logic [31:0] w;
      logic [7:0]  x;
      int          total;
      int          w0;
      int          d0;
      int          got;
      int          gap;
      int          guard;
      int          exp_done;
      int          exp_err;

      total = (n == 0) ? DEPTH : n;
      stream.push_back(8'(n));
      for (int i = 0; i < total; i++) begin
         w = (i == 0 && use_first) ? first_w : $urandom;
         words.push_back(w);
         stream.push_back(w[31:24]);
         stream.push_back(w[23:16]);
         stream.push_back(w[15:8]);
         stream.push_back(w[7:0]);
      end
      exp_done = 1;
      exp_err  = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'd0;
      foreach (stream[i]) x = x ^ stream[i];
      if (bad) begin
         x        = x ^ 8'h03;
         exp_done = 0;
         exp_err  = 1;
      end
      stream.push_back(x);
`endif

      w0 = wa_q.size();
      d0 = done_cnt;

      pulse_start();
      check({tag, "_busy_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_busy_hold"},  64'(cpu_hold), 64'd1);
      check({tag, "_busy_err"},   64'(err),      64'd0);
      check({tag, "_busy_addr"},  64'(wr_addr),  64'(BASE));

      foreach (stream[i]) begin
         if (i == start_at) pulse_start();
         case (gap_kind)
            0:       gap = 0;
            1:       gap = 1;
            default: gap = $urandom_range(0, 3);
         endcase
         send_byte(stream[i], gap);
      end

      guard = 0;
      while (done_cnt == d0 && guard < 12) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);

      got = wa_q.size() - w0;
      check({tag, "_n_writes"}, 64'(got), 64'(total));
      for (int i = 0; i < total && i < got; i++) begin
         check({tag, "_addr"}, 64'(wa_q[w0 + i]), 64'((BASE + i) % DEPTH));
         check({tag, "_data"}, 64'(wd_q[w0 + i]), 64'(words[i]));
      end
      check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(exp_done));
      if (exp_done == 1) check({tag, "_hold_at_done"}, 64'(hold_at_done), 64'd0);
      check({tag, "_hold_after"},  64'(cpu_hold), 64'(exp_err));
      check({tag, "_err_after"},   64'(err),      64'(exp_err));
      check({tag, "_ready_after"}, 64'(in_ready), 64'd0);
      check({tag, "_addr_after"},  64'(wr_addr),  64'((BASE + total) % DEPTH));
   endtask

   initial begin
      int w0;

      // Reset state
      #1 rst = 1'b1;
      #2 check_reset("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("idle");

      // Single word 01 12 00 05
      run_load("one_word", 1, 0, -1, 1'b1, 32'h0112_0005, 1'b0);

      // Three words with in_valid toggling every cycle
      run_load("toggle", 3, 1, -1, 1'b0, 32'd0, 1'b0);

      // Stray start in the middle of the data phase
      run_load("start_in_data", 2, 2, 3, 1'b0, 32'd0, 1'b0);

      // Random small loads with random stalls
      for (int k = 0; k < 4; k++) begin
         run_load("random", $urandom_range(1, 6), 2, -1, 1'b0, 32'd0, 1'b0);
      end

      // Reset after two data bytes: partial word must never be written
      w0 = wa_q.size();
      pulse_start();
      send_byte(8'd1, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      #3 rst = 1'b1;
      #1 check_reset("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_no_write", 64'(wa_q.size() - w0), 64'd0);
      run_load("after_abort", 1, 0, -1, 1'b1, 32'h1122_3344, 1'b0);

      // N=0: full address range, wrapping back to BASE
      run_load("full_wrap", 0, 0, -1, 1'b0, 32'd0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      run_load("csum_good", 1, 0, -1, 1'b1, 32'hAABB_CCDD, 1'b0);
      run_load("csum_bad",  1, 0, -1, 1'b1, 32'hAABB_CCDD, 1'b1);
      run_load("csum_recover", 2, 2, -1, 1'b0, 32'd0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the instruction-memory address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, the address where the first loaded word is written.
REQ-003 SHALL provide clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide start  input  1  one-cycle request to begin a load.
REQ-006 SHALL provide in_valid  input  1  byte-stream valid.
REQ-007 SHALL provide in_data  input  8  byte-stream data.
REQ-008 SHALL provide in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL provide wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL provide wr_addr  output  ADDR_W  instruction-memory write address.
REQ-011 SHALL provide wr_data  output  32  instruction word to write.
REQ-012 SHALL provide cpu_hold  output  1  holds the CPU pc and register writes while high.
REQ-013 SHALL provide done  output  1  one-cycle pulse on successful load completion.
REQ-014 SHALL provide err  output  1  sticky load-error flag.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, CSUM, FIN; a byte is accepted only when in_valid and in_ready are both high.
REQ-016 SHALL drive in_ready high exactly in LEN, DATA and CSUM; low in IDLE and FIN.
REQ-017 SHALL move IDLE->LEN on start, clearing err, the byte counter and the checksum accumulator, and setting wr_addr to BASE_ADDR and cpu_hold to 1.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 In LEN, SHALL take the accepted byte as word count N, with N=0 meaning 2**ADDR_W words, then go to DATA.
REQ-020 In DATA, SHALL assemble each word MSB first: the 1st accepted byte goes to wr_data[31:24] and the 4th to wr_data[7:0].
REQ-021 SHALL pulse wr_en for one cycle, with stable wr_data and wr_addr, in the cycle after each word's 4th byte is accepted.
REQ-022 SHALL increment wr_addr by 1 modulo 2**ADDR_W after each wr_en.
REQ-023 Stalls (in_valid low) SHALL hold all state, with no timeout.
REQ-024 After the N-th word is written, SHALL go to CSUM when checksum is compiled in, otherwise to FIN.
REQ-025 In FIN, SHALL pulse done one cycle, drop cpu_hold to 0 in the same cycle, and return to IDLE the next cycle.
REQ-026 SHALL keep wr_en low in every state except the cycle defined in REQ-021.

Reset
REQ-027 On rst (asynchronous, any state, including mid-word), SHALL enter IDLE and set in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, err=0.
REQ-028 A partially assembled word SHALL be discarded on reset and never written.

Configuration
REQ-029 When macro IMEM_LOADER_CHECKSUM_EN is defined, SHALL keep an 8-bit XOR of the N byte and all data bytes.
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, SHALL accept one trailing byte in CSUM: on match go to FIN; on mismatch set err=1, keep cpu_hold=1, give no done pulse, and return to IDLE.
REQ-031 When IMEM_LOADER_CHECKSUM_EN is undefined, SHALL omit CSUM, the checksum logic and its hardware, and hold err constant 0.

Verification
REQ-032 SHALL cover: after rst, start, N=1, bytes 01 12 00 05 -> one wr_en with addr 0x00, data 0x01120005, then done, cpu_hold=0.
REQ-033 SHALL cover: N=3 with in_valid toggling every cycle -> three writes at addrs 0,1,2 with correct words, and no write during stalls.
REQ-034 SHALL cover: N=0, ADDR_W=8 -> 256 writes, addr 0x00..0xFF then wrap to 0x00, done after the 256th write.
REQ-035 SHALL cover: rst asserted after 2 data bytes, then a new load with N=1 -> no write from the aborted load, and the new word lands at BASE_ADDR.
REQ-036 SHALL cover: with IMEM_LOADER_CHECKSUM_EN, N=1, bytes AA BB CC DD and checksum 0x01 (correct) -> done; with checksum 0x02 -> err=1, cpu_hold=1, no done.
REQ-037 SHALL cover: start pulsed in DATA -> ignored, with load progress unchanged.
